// File: rtl/stream_descale_sink.sv
// Descaling sink: checks the low SHIFT bits are zero, shifts right by SHIFT, buffers in a DEPTH-entry FWFT FIFO.
// Optional STREAM_DESCALE_SINK_THROTTLE_EN adds an LFSR that randomly masks t0_ready.
module stream_descale_sink #(
    parameter int DW    = 32,
    parameter int SHIFT = 2,
    parameter int DEPTH = 4,
    parameter int CW    = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rstf,
    input  logic [DW-1:0] t0_data,
    input  logic          t0_valid,
    output logic          t0_ready,
    output logic [DW-1:0] i0_data,
    output logic          i0_valid,
    input  logic          i0_ready,
    input  logic          clr,
    output logic [CW-1:0] word_cnt,
    output logic [CW-1:0] err_cnt,
    output logic          err_flag,
    output logic [LW-1:0] level
);

    logic [AW:0]   wptr_q, rptr_q;
    logic [DW-1:0] mem_q [DEPTH];
    logic          ready_q;
    logic [CW-1:0] word_cnt_q, err_cnt_q;
    logic          err_flag_q;
    logic [LW-1:0] level_d;
    logic          empty, push, pop, bad;

    assign empty    = (wptr_q == rptr_q);
    assign level    = wptr_q - rptr_q;
    assign i0_valid = !empty;
    assign i0_data  = mem_q[rptr_q[AW-1:0]];
    assign push     = t0_valid & t0_ready;
    assign pop      = i0_valid & i0_ready;
    assign bad      = |t0_data[SHIFT-1:0];

`ifdef STREAM_DESCALE_SINK_THROTTLE_EN
    logic [7:0] lfsr_q;

    // x^8+x^6+x^5+x^4+1, Fibonacci form, free-running
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) lfsr_q <= 8'hA5;
        else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    assign t0_ready = ready_q & lfsr_q[0];
`else
    assign t0_ready = ready_q;
`endif

    always_comb begin
        level_d = level;
        if (push && !pop)      level_d = level + 1'b1;
        else if (pop && !push) level_d = level - 1'b1;
    end

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            ready_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            // ready looks at next-state occupancy only, so i0_ready never reaches t0_ready combinationally
            ready_q <= (level_d < LW'(DEPTH));
            if (push) begin
                mem_q[wptr_q[AW-1:0]] <= t0_data >> SHIFT;
                wptr_q                <= wptr_q + 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
        end else if (clr) begin
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
        end else if (push) begin
            if (word_cnt_q != '1)       word_cnt_q <= word_cnt_q + 1'b1;
            if (bad && err_cnt_q != '1) err_cnt_q  <= err_cnt_q + 1'b1;
            if (bad)                    err_flag_q <= 1'b1;
        end
    end

    assign word_cnt = word_cnt_q;
    assign err_cnt  = err_cnt_q;
    assign err_flag = err_flag_q;

endmodule

// File: tb/tb_stream_descale_sink.sv
// Scoreboard bench for stream_descale_sink: stimulus queues expected outputs, a monitor pops and compares.
module tb_stream_descale_sink;

    logic        clk = 1'b0;
    logic        rstf;
    logic [31:0] t0_data, i0_data;
    logic        t0_valid, t0_ready, i0_valid, i0_ready, clr, err_flag;
    logic [15:0] word_cnt, err_cnt;
    logic [2:0]  level;

    logic [31:0] s_data, s_odata;
    logic        s_valid, s_ready, s_ovalid, s_flag;
    logic [3:0]  s_word, s_err;
    logic [2:0]  s_level;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_acc = 0;
    int first_acc = 0;
    int max_level = 0;
    bit streaming = 0;
    logic [31:0] expq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stream_descale_sink #(.DW(32), .SHIFT(2), .DEPTH(4), .CW(16)) u_dut (
        .clk(clk), .rstf(rstf), .t0_data(t0_data), .t0_valid(t0_valid), .t0_ready(t0_ready),
        .i0_data(i0_data), .i0_valid(i0_valid), .i0_ready(i0_ready), .clr(clr),
        .word_cnt(word_cnt), .err_cnt(err_cnt), .err_flag(err_flag), .level(level)
    );

    stream_descale_sink #(.DW(32), .SHIFT(2), .DEPTH(4), .CW(4)) u_sat (
        .clk(clk), .rstf(rstf), .t0_data(s_data), .t0_valid(s_valid), .t0_ready(s_ready),
        .i0_data(s_odata), .i0_valid(s_ovalid), .i0_ready(1'b1), .clr(1'b0),
        .word_cnt(s_word), .err_cnt(s_err), .err_flag(s_flag), .level(s_level)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: a handshake seen at the negedge completes at the next posedge
    always @(negedge clk) begin
        if (rstf && i0_valid && i0_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%h required=none", i0_data);
            end else begin
                chk("i0_data", i0_data, expq.pop_front());
            end
        end
        if (streaming && int'(level) > max_level) max_level = int'(level);
    end

    task automatic send(input logic [31:0] d, input logic [31:0] e);
        int n = 0;
        t0_data  = d;
        t0_valid = 1'b1;
        @(negedge clk);
        while (!t0_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!t0_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=stalled required=accept data=%h", d);
            t0_valid = 1'b0;
            return;
        end
        expq.push_back(e);
        last_acc = cyc;
        @(posedge clk);
        #1;
        t0_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((expq.size() != 0 || level != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", {31'd0, (expq.size() == 0 && level == 0)}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int n;
        logic [6:0] pat;
        rstf = 1'b0; t0_data = '0; t0_valid = 1'b0; i0_ready = 1'b1; clr = 1'b0;
        s_data = '0; s_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_t0_ready", {31'd0, t0_ready}, 32'd0);
        chk("rst_i0_valid", {31'd0, i0_valid}, 32'd0);
        chk("rst_i0_data", i0_data, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
        chk("rst_err_flag", {31'd0, err_flag}, 32'd0);
        rstf = 1'b1;
        @(negedge clk);
        chk("ready_before_edge", {31'd0, t0_ready}, 32'd0);
`ifdef STREAM_DESCALE_SINK_THROTTLE_EN
        // LFSR bit 0 after edges 1..7 from seed A5: 4A,95,2A,54,A9,53,A7
        pat = 7'b1110010;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("lfsr_ready", {31'd0, t0_ready}, {31'd0, pat[i]});
        end
`else
        pat = '0;
        @(negedge clk);
        chk("ready_after_edge", {31'd0, t0_ready}, 32'd1);
`endif
        @(posedge clk);
        #1;

        // Single word: 0x10 -> 0x4, visible the cycle after acceptance
        send(32'h10, 32'h4);
        @(negedge clk);
        chk("single_valid", {31'd0, i0_valid}, 32'd1);
        chk("single_data", i0_data, 32'h4);
        repeat (2) @(negedge clk);
        chk("single_word_cnt", {16'd0, word_cnt}, 32'd1);
        chk("single_err_cnt", {16'd0, err_cnt}, 32'd0);
        drain();

        // Backpressure fill
        i0_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 8; i++) send(32'(i * 4), 32'(i));
            end
            begin
                n = 0;
                while (level != 3'd4 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                chk("fill_level", {29'd0, level}, 32'd4);
                chk("fill_ready", {31'd0, t0_ready}, 32'd0);
                repeat (3) @(negedge clk);
                chk("fill_still_4", {29'd0, level}, 32'd4);
                chk("fill_word_cnt", {16'd0, word_cnt}, 32'd5);
                @(posedge clk);
                #1;
                i0_ready = 1'b1;
            end
        join
        drain();

        // Streaming 100 words
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        streaming = 1;
        max_level = 0;
        for (int i = 1; i <= 100; i++) begin
            send(32'(i) << 2, 32'(i));
            if (i == 1) first_acc = last_acc;
        end
        drain();
        streaming = 0;
        chk("stream_max_level", 32'(max_level), 32'd1);
        chk("stream_word_cnt", {16'd0, word_cnt}, 32'd100);
`ifndef STREAM_DESCALE_SINK_THROTTLE_EN
        chk("stream_cycles", 32'(last_acc - first_acc), 32'd99);
`endif

        // Error word, then clr coincident with a push
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        send(32'h13, 32'h4);
        repeat (2) @(negedge clk);
        chk("err_cnt", {16'd0, err_cnt}, 32'd1);
        chk("err_flag", {31'd0, err_flag}, 32'd1);
        chk("err_word_cnt", {16'd0, word_cnt}, 32'd1);
        @(posedge clk);
        #1;
        clr = 1'b1;
        send(32'h8, 32'h2);
        clr = 1'b0;
        @(negedge clk);
        chk("clr_word_cnt", {16'd0, word_cnt}, 32'd0);
        chk("clr_err_cnt", {16'd0, err_cnt}, 32'd0);
        chk("clr_err_flag", {31'd0, err_flag}, 32'd0);
        drain();

        // Saturation on the CW=4 instance: 20 bad words
        acc = 0;
        n = 0;
        s_valid = 1'b1;
        s_data = 32'h1;
        while (acc < 20 && n < 500) begin
            @(negedge clk);
            if (s_ready) acc++;
            n++;
            @(posedge clk);
            #1;
            s_data = 32'((acc % 3) + 1) | 32'(acc << 4);
            if (acc == 20) s_valid = 1'b0;
        end
        s_valid = 1'b0;
        @(negedge clk);
        chk("sat_accepted", 32'(acc), 32'd20);
        chk("sat_word_cnt", {28'd0, s_word}, 32'd15);
        chk("sat_err_cnt", {28'd0, s_err}, 32'd15);
        chk("sat_err_flag", {31'd0, s_flag}, 32'd1);
        @(posedge clk);
        #1;

        // Reset mid-stream with 3 buffered words
        i0_ready = 1'b0;
        send(32'h40, 32'h10);
        send(32'h44, 32'h11);
        send(32'h48, 32'h12);
        @(negedge clk);
        chk("mid_level", {29'd0, level}, 32'd3);
        chk("mid_valid", {31'd0, i0_valid}, 32'd1);
        rstf = 1'b0;
        #1;
        chk("mid_rst_level", {29'd0, level}, 32'd0);
        chk("mid_rst_valid", {31'd0, i0_valid}, 32'd0);
        chk("mid_rst_data", i0_data, 32'd0);
        chk("mid_rst_ready", {31'd0, t0_ready}, 32'd0);
        expq.delete();
        @(posedge clk);
        #1;
        rstf = 1'b1;
        i0_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_level", {29'd0, level}, 32'd0);
        chk("post_rst_word_cnt", {16'd0, word_cnt}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
